// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between two
// writeback requesters; the winning write is registered and driven one cycle later.
module rf_write_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          en,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_wsel,
    input  logic [DW-1:0] req0_wdat,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_wsel,
    input  logic [DW-1:0] req1_wdat,
    output logic          req1_ready,
    output logic          WEN,
    output logic [AW-1:0] wsel,
    output logic [DW-1:0] wdat,
    output logic          last_grant
);

    logic          wen_q, wen_d;
    logic [AW-1:0] wsel_q, wsel_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic          lastGrant_q, lastGrant_d;
    logic          grant0, grant1;

    // On a tie the requester that was not served last wins, so grants alternate.
    always_comb begin
        grant0 = en && req0_valid && (!req1_valid || lastGrant_q);
        grant1 = en && req1_valid && (!req0_valid || !lastGrant_q);
    end

    always_comb begin
        wen_d       = 1'b0;
        wsel_d      = wsel_q;
        wdat_d      = wdat_q;
        lastGrant_d = lastGrant_q;
        if (grant0) begin
            wen_d       = (req0_wsel != '0);
            wsel_d      = req0_wsel;
            wdat_d      = req0_wdat;
            lastGrant_d = 1'b0;
        end else if (grant1) begin
            wen_d       = (req1_wsel != '0);
            wsel_d      = req1_wsel;
            wdat_d      = req1_wdat;
            lastGrant_d = 1'b1;
        end
    end

    // Reset discards any accept made in the same cycle; last_grant=1 lets req0 win the first tie.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wen_q       <= 1'b0;
            wsel_q      <= '0;
            wdat_q      <= '0;
            lastGrant_q <= 1'b1;
        end else begin
            wen_q       <= wen_d;
            wsel_q      <= wsel_d;
            wdat_q      <= wdat_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign WEN        = wen_q;
    assign wsel       = wsel_q;
    assign wdat       = wdat_q;
    assign last_grant = lastGrant_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter: reset, single grants, r0 discard,
// alternating conflicts, stalls and reset colliding with an accept.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          en;
    logic          req0_valid;
    logic [AW-1:0] req0_wsel;
    logic [DW-1:0] req0_wdat;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_wsel;
    logic [DW-1:0] req1_wdat;
    logic          req1_ready;
    logic          WEN;
    logic [AW-1:0] wsel;
    logic [DW-1:0] wdat;
    logic          last_grant;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(.DW(DW), .AW(AW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .req0_valid (req0_valid),
        .req0_wsel  (req0_wsel),
        .req0_wdat  (req0_wdat),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_wsel  (req1_wsel),
        .req1_wdat  (req1_wdat),
        .req1_ready (req1_ready),
        .WEN        (WEN),
        .wsel       (wsel),
        .wdat       (wdat),
        .last_grant (last_grant)
    );

    always #5 CLK = ~CLK;

    task automatic applyStimulus(input logic r, input logic e,
                                 input logic v0, input logic [AW-1:0] s0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] s1, input logic [DW-1:0] d1);
        @(negedge CLK);
        RST        = r;
        en         = e;
        req0_valid = v0;
        req0_wsel  = s0;
        req0_wdat  = d0;
        req1_valid = v1;
        req1_wsel  = s1;
        req1_wdat  = d1;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkRegs(input string tag, input logic expWen, input logic [AW-1:0] expSel,
                             input logic [DW-1:0] expDat, input logic expLast);
        @(posedge CLK);
        #1;
        checkOutput({tag, ".WEN"}, 32'(WEN), 32'(expWen));
        checkOutput({tag, ".wsel"}, 32'(wsel), 32'(expSel));
        checkOutput({tag, ".wdat"}, wdat, expDat);
        checkOutput({tag, ".last_grant"}, 32'(last_grant), 32'(expLast));
    endtask

    task automatic checkReady(input string tag, input logic exp0, input logic exp1);
        checkOutput({tag, ".req0_ready"}, 32'(req0_ready), 32'(exp0));
        checkOutput({tag, ".req1_ready"}, 32'(req1_ready), 32'(exp1));
    endtask

    initial begin
        RST = 1'b1; en = 1'b1;
        req0_valid = 1'b1; req0_wsel = 5'd9; req0_wdat = 32'hAAAA_5555;
        req1_valid = 1'b0; req1_wsel = '0;   req1_wdat = '0;

        // Reset held two cycles with a pending req0; nothing may reach the write port.
        checkRegs("rst1", 1'b0, 5'd0, 32'h0, 1'b1);
        checkRegs("rst2", 1'b0, 5'd0, 32'h0, 1'b1);
        applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        checkReady("idle", 1'b0, 1'b0);
        checkRegs("postRst", 1'b0, 5'd0, 32'h0, 1'b1);

        // Single req0 write, one-cycle latency, then WEN drops while wsel/wdat hold.
        applyStimulus(0, 1, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0);
        checkReady("r0only", 1'b1, 1'b0);
        checkRegs("r0write", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        checkRegs("r0after", 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0);

        // req1 writing register 0: accepted, but WEN stays low.
        applyStimulus(0, 1, 0, 5'd0, 32'h0, 1, 5'd0, 32'h0000_1234);
        checkReady("r1zero", 1'b0, 1'b1);
        checkRegs("r1zeroWr", 1'b0, 5'd0, 32'h0000_1234, 1'b1);

        // Both valid four cycles: grants 0,1,0,1 with a write every cycle.
        for (int i = 0; i < 4; i++) begin
            automatic logic g = logic'(i % 2);
            applyStimulus(0, 1, 1, 5'd3, 32'h3333_0000 + 32'(i), 1, 5'd7, 32'h7777_0000 + 32'(i));
            checkReady($sformatf("alt%0d", i), !g, g);
            checkRegs($sformatf("altWr%0d", i), 1'b1, g ? 5'd7 : 5'd3,
                      g ? 32'h7777_0000 + 32'(i) : 32'h3333_0000 + 32'(i), g);
        end
        applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        checkRegs("altEnd", 1'b0, 5'd7, 32'h7777_0003, 1'b1);

        // Stall with both valid: no ready, no write, last_grant frozen at 1.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 5'd3, 32'hC0DE_0003, 1, 5'd7, 32'hC0DE_0007);
            checkReady($sformatf("stall%0d", i), 1'b0, 1'b0);
            checkRegs($sformatf("stallWr%0d", i), 1'b0, 5'd7, 32'h7777_0003, 1'b1);
        end
        applyStimulus(0, 1, 1, 5'd3, 32'hC0DE_0003, 1, 5'd7, 32'hC0DE_0007);
        checkReady("unstall", 1'b1, 1'b0);
        checkRegs("unstallWr", 1'b1, 5'd3, 32'hC0DE_0003, 1'b0);

        // Second stall after a req0 grant: resuming must serve req1.
        applyStimulus(0, 0, 1, 5'd3, 32'hC0DE_0003, 1, 5'd7, 32'hC0DE_0007);
        checkReady("stallB", 1'b0, 1'b0);
        checkRegs("stallBWr", 1'b0, 5'd3, 32'hC0DE_0003, 1'b0);
        applyStimulus(0, 1, 1, 5'd3, 32'hC0DE_0003, 1, 5'd7, 32'hC0DE_0007);
        checkReady("unstallB", 1'b0, 1'b1);
        checkRegs("unstallBWr", 1'b1, 5'd7, 32'hC0DE_0007, 1'b1);

        // Reset in the same cycle as a req1 accept: the write is lost.
        applyStimulus(0, 1, 1, 5'd4, 32'h4444_4444, 0, 5'd0, 32'h0);
        checkRegs("preRst", 1'b1, 5'd4, 32'h4444_4444, 1'b0);
        applyStimulus(1, 1, 0, 5'd0, 32'h0, 1, 5'd12, 32'hBAD0_BAD0);
        checkRegs("rstAccept", 1'b0, 5'd0, 32'h0, 1'b1);
        applyStimulus(0, 1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
        checkRegs("rstAfter", 1'b0, 5'd0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
